// File: rtl/riscv_pkg.sv
// ============================================================================
// riscv_pkg : shared datapath widths for the RISC-V core (rev 1.0)
// ============================================================================
`default_nettype none

package riscv_pkg;

  localparam int XLEN        = 32;
  localparam int DMEM_ADDR_W = 11;

  function automatic int dmem_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/data_memory.sv
// ============================================================================
// data_memory : 2**ADDR_W x DATA_W word memory, sync write / async read,
//               asynchronous active-low clear of the whole array (rev 1.0)
// ============================================================================
`default_nettype none

module data_memory
  import riscv_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = XLEN
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_MemWrite,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data
);

  localparam int DEPTH = dmem_depth(ADDR_W);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (i_MemWrite) begin
      mem_d[i_addr] = i_data;
    end
  end

  // Reset clears every word immediately, overriding any write on that cycle.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign o_data = mem_q[i_addr];

endmodule

`default_nettype wire

// File: tb/tb_data_memory.sv
// ============================================================================
// tb_data_memory : directed + randomized check of data_memory against an
//                  array reference model (rev 1.0)
// ============================================================================
`default_nettype none

module tb_data_memory;

  localparam int AW    = 11;
  localparam int DW    = 32;
  localparam int DEPTH = 2048;

  logic          clk;
  logic          rstn;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;

  logic [DW-1:0] model [DEPTH];

  int n_vec;
  int n_err;

  data_memory #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .i_MemWrite (we),
    .i_addr     (addr),
    .i_data     (wdata),
    .o_data     (rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  // Advance one rising edge, mirror its effect in the model, settle 1ns after.
  task automatic tick();
    @(posedge clk);
    if (rstn === 1'b1 && we === 1'b1) model[addr] = wdata;
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    we = 1'b1; addr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [AW-1:0] a,
                          input logic [DW-1:0] exp);
    addr = a;
    #1;
    check(tag, rdata, exp);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rstn = 1'b1; we = 1'b0; addr = '0; wdata = '0;
    for (int i = 0; i < DEPTH; i++) model[i] = 'x;

    // Power-on reset held for two cycles
    #2 rstn = 1'b0;
    model_clear();
    repeat (2) tick();
    read_chk("rst_a0",    11'd0,    32'h0);
    read_chk("rst_a1",    11'd1,    32'h0);
    read_chk("rst_a2047", 11'd2047, 32'h0);
    rstn = 1'b1;
    tick();

    do_write(11'd0, 32'hA5A5A5A5);
    tick();
    read_chk("wr_a0", 11'd0, 32'hA5A5A5A5);

    do_write(11'd1, 32'h5A5A5A5A);
    read_chk("wr_a1", 11'd1, 32'h5A5A5A5A);
    read_chk("comb_a0", 11'd0, 32'hA5A5A5A5);

    do_write(11'd1027, 32'hDEADBEEF);
    read_chk("wr_a1027", 11'd1027, 32'hDEADBEEF);
    read_chk("a1026_zero", 11'd1026, 32'h0);
    do_write(11'd2047, 32'h12345678);
    read_chk("wr_a2047", 11'd2047, 32'h12345678);

    // Write enable low: nothing may change
    we = 1'b0; addr = 11'd1; wdata = 32'hFFFFFFFF;
    repeat (3) tick();
    read_chk("gated_a1", 11'd1, 32'h5A5A5A5A);

    // Read-during-write: old word before the edge, new word after
    we = 1'b1; addr = 11'd0; wdata = 32'h0BADF00D;
    #1 check("rdw_before", rdata, 32'hA5A5A5A5);
    tick();
    check("rdw_after", rdata, 32'h0BADF00D);
    we = 1'b0;

    // Mid-run reset pulsed between edges
    @(negedge clk);
    rstn = 1'b0;
    model_clear();
    read_chk("midrst_a0",    11'd0,    32'h0);
    read_chk("midrst_a1",    11'd1,    32'h0);
    read_chk("midrst_a1027", 11'd1027, 32'h0);

    // Write attempted while reset is held
    we = 1'b1; addr = 11'd5; wdata = 32'hCAFEBABE;
    tick();
    we = 1'b0;
    rstn = 1'b1;
    read_chk("wr_in_rst", 11'd5, 32'h0);
    do_write(11'd5, 32'h00C0FFEE);
    read_chk("first_wr_after_rst", 11'd5, 32'h00C0FFEE);

    // Randomized traffic against the reference array
    for (int it = 0; it < 400; it++) begin
      int unsigned op;
      op = $urandom_range(0, 99);
      if (op < 2) begin
        @(negedge clk);
        rstn = 1'b0;
        model_clear();
        #1 rstn = 1'b1;
        addr = AW'($urandom);
        #1 check("rnd_rst", rdata, model[addr]);
      end else begin
        we    = (op < 60);
        addr  = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 15))
                                            : AW'($urandom);
        wdata = $urandom;
        #1 check("rnd_pre", rdata, model[addr]);
        tick();
        check("rnd_post", rdata, model[addr]);
        we = 1'b0;
        addr = AW'($urandom_range(0, 15));
        #1 check("rnd_scan", rdata, model[addr]);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
